// File: rtl/joy_cond_pkg.sv
// Shared definitions for the DB15 joystick conditioning stage:
// button bit positions and the menu-combo FSM state type.
package joy_cond_pkg;

  localparam int JOY_R     = 0;
  localparam int JOY_L     = 1;
  localparam int JOY_D     = 2;
  localparam int JOY_U     = 3;
  localparam int JOY_A     = 4;
  localparam int JOY_B     = 5;
  localparam int JOY_C     = 6;
  localparam int JOY_DD    = 7;
  localparam int JOY_E     = 8;
  localparam int JOY_F     = 9;
  localparam int JOY_START = 10;
  localparam int JOY_SEL   = 11;

  localparam int JOY_BITS  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FIRED = 2'd2
  } menu_state_t;

endpackage

// File: rtl/joy_db15_debounce.sv
// Single-bit tick-sampled debouncer: the stable value flips only after
// DB_CNT consecutive tick samples that disagree with it.
module joy_db15_debounce #(
  parameter int DB_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic dout
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 1'b0;
      cnt  <= 4'd0;
    end else if (tick) begin
      if (din == dout) begin
        cnt <= 4'd0;
      end else if (cnt == 4'(DB_CNT - 1)) begin
        dout <= ~dout;
        cnt  <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/joy_db15_cond.sv
// DB15 joystick conditioner: sync, debounce, Start+Select menu combo and
// optional button-A autofire (enabled by defining JTFRAME_JOY_AUTOFIRE_EN).
//
// state | meaning
// IDLE  | combo not held
// HOLD  | Start+Select held, counting ticks toward menu
// FIRED | menu pulse issued, Start/Select masked until both released
module joy_db15_cond
  import joy_cond_pkg::*;
#(
  parameter int TICK_DIV   = 48000,
  parameter int DB_CNT     = 4,
  parameter int HOLD_TICKS = 1000,
  parameter int AF_HALF    = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] joy1_in,
  input  logic [15:0] joy2_in,
  output logic [15:0] joy1_out,
  output logic [15:0] joy2_out,
  output logic        upd,
  output logic        menu,
  output logic [1:0]  af_on
);

  localparam int TW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HW  = $clog2(HOLD_TICKS + 1);

  logic [TW-1:0]             tick_cnt;
  logic                      tick;
  logic [1:0][JOY_BITS-1:0]  sync1, sync2, db;
  logic [HW-1:0]             hold_cnt;
  menu_state_t               state;
  logic                      combo, combo_none;
  logic [15:0]               nxt1, nxt2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {joy2_in[JOY_BITS-1:0], joy1_in[JOY_BITS-1:0]};
      sync2 <= sync1;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  for (genvar p = 0; p < 2; p++) begin : g_player
    for (genvar b = 0; b < JOY_BITS; b++) begin : g_bit
      joy_db15_debounce #(.DB_CNT(DB_CNT)) u_db (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .din   (sync2[p][b]),
        .dout  (db[p][b])
      );
    end
  end

  assign combo      =  db[0][JOY_START] &  db[0][JOY_SEL];
  assign combo_none = ~db[0][JOY_START] & ~db[0][JOY_SEL];

  // Release is checked before the hold limit so a release on the
  // completing tick cancels the menu request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      menu     <= 1'b0;
    end else begin
      menu <= 1'b0;
      case (state)
        IDLE: begin
          if (combo) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (tick) begin
            if (!combo) begin
              state <= IDLE;
            end else if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
              menu  <= 1'b1;
              state <= FIRED;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        FIRED: begin
          if (combo_none) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JTFRAME_JOY_AUTOFIRE_EN
  localparam int AFW = $clog2(AF_HALF + 1);

  logic [AFW-1:0] af_cnt;
  logic           af_phase;
  logic [1:0]     f_prev;
  logic [1:0]     f_now;

  assign f_now = {db[1][JOY_F], db[0][JOY_F]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
      f_prev   <= 2'b00;
      af_on    <= 2'b00;
    end else begin
      f_prev <= f_now;
      af_on  <= af_on ^ (f_now & ~f_prev);
      if (tick) begin
        if (af_cnt == AFW'(AF_HALF - 1)) begin
          af_cnt   <= '0;
          af_phase <= ~af_phase;
        end else begin
          af_cnt <= af_cnt + 1'b1;
        end
      end
    end
  end
`else
  logic unused_af;
  assign unused_af = (AF_HALF > 0);
  assign af_on     = 2'b00;
`endif

  logic unused_hi;
  assign unused_hi = ^{joy1_in[15:JOY_BITS], joy2_in[15:JOY_BITS]};

  always_comb begin
    nxt1 = {4'b0000, db[0]};
    nxt2 = {4'b0000, db[1]};
    if (state == FIRED) begin
      nxt1[JOY_START] = 1'b0;
      nxt1[JOY_SEL]   = 1'b0;
    end
`ifdef JTFRAME_JOY_AUTOFIRE_EN
    nxt1[JOY_F] = 1'b0;
    nxt2[JOY_F] = 1'b0;
    if (af_on[0]) nxt1[JOY_A] = db[0][JOY_A] & af_phase;
    if (af_on[1]) nxt2[JOY_A] = db[1][JOY_A] & af_phase;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      joy1_out <= '0;
      joy2_out <= '0;
      upd      <= 1'b0;
    end else begin
      joy1_out <= nxt1;
      joy2_out <= nxt2;
      upd      <= (nxt1 != joy1_out) || (nxt2 != joy2_out);
    end
  end

endmodule
